// File: rtl/nano_pkg.sv
// Shared types for the Nano CPU / SPI programmer RAM arbiter.
// No logic; state encoding and default wait budget only.
// Not applicable.
package nano_pkg;

  // Arbiter ownership modes
  typedef enum logic [1:0] {
    ARB_CPU   = 2'd0,
    ARB_FORCE = 2'd1,
    ARB_LOCK  = 2'd2
  } arb_state_t;

  // Default number of denied SPI cycles before a slot is forced
  localparam int MAX_WAIT_DEF = 4;

  // Width of the wait counter (covers MAX_WAIT up to 255)
  localparam int WAIT_W = 8;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive denied SPI cycles; flags the last cycle before a forced slot.
// hit is combinational from the counter register; the count updates one edge after inc/clr.
// No handshake; clr wins over inc, and the count holds at MAX_WAIT instead of wrapping.
module arb_wait_counter
  import nano_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  // Next count: clear on grant or idle, otherwise count denials up to the ceiling
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < WAIT_W'(MAX_WAIT))) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  // Counter register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/nano_ram_arbiter.sv
// Shares one single-port sync RAM between the Nano CPU and the SPI programmer.
// Grants and RAM port are combinational; rvalid and spi_forced are registered (1 cycle).
// Denied requesters must hold req/address; nothing is queued, the loser simply waits.
module nano_ram_arbiter
  import nano_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADD_WIDTH  = 4,
  parameter int MAX_WAIT   = MAX_WAIT_DEF
) (
  input  logic                  CLK,
  input  logic                  NRST,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADD_WIDTH-1:0]  cpu_add,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rvalid,
  input  logic                  spi_req,
  input  logic                  spi_we,
  input  logic [ADD_WIDTH-1:0]  spi_add,
  input  logic [DATA_WIDTH-1:0] spi_wdata,
  output logic                  spi_gnt,
  output logic [DATA_WIDTH-1:0] spi_rdata,
  output logic                  spi_rvalid,
  input  logic                  spi_lock,
  output logic                  ram_we,
  output logic [ADD_WIDTH-1:0]  ram_add,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  spi_forced
);

  arb_state_t state_q;
  arb_state_t state_d;
  logic       cpu_rvalid_q;
  logic       cpu_rvalid_d;
  logic       spi_rvalid_q;
  logic       spi_rvalid_d;
  logic       spi_forced_q;
  logic       spi_forced_d;
  logic       wait_hit;

  // Denied SPI cycles; clears whenever SPI is served or stops asking
  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_cnt (
    .clk  (CLK),
    .nrst (NRST),
    .clr  (spi_gnt | ~spi_req),
    .inc  (spi_req & ~spi_gnt),
    .hit  (wait_hit)
  );

  // Grant decode and next-state; grants are held off while reset is asserted
  always_comb begin
    cpu_gnt = 1'b0;
    spi_gnt = 1'b0;
    state_d = state_q;
    if (NRST) begin
      unique case (state_q)
        ARB_FORCE: begin
          spi_gnt = spi_req;
          state_d = ARB_CPU;
        end
        ARB_LOCK: begin
          if (spi_lock) begin
            spi_gnt = spi_req;
          end else begin
            // Lock released: CPU priority resumes in this very cycle
            cpu_gnt = cpu_req;
            spi_gnt = spi_req & ~cpu_req;
            state_d = ARB_CPU;
          end
        end
        default: begin
          cpu_gnt = cpu_req;
          spi_gnt = spi_req & ~cpu_req;
          if (wait_hit && spi_req && !spi_gnt) begin
            state_d = ARB_FORCE;
          end
        end
      endcase
      // A granted, locking SPI access always wins the next-state choice
      if (spi_gnt && spi_lock) begin
        state_d = ARB_LOCK;
      end
    end
  end

  // Registered side outputs derived from this cycle's grant decisions
  always_comb begin
    cpu_rvalid_d = cpu_gnt & ~cpu_we;
    spi_rvalid_d = spi_gnt & ~spi_we;
    spi_forced_d = (state_d == ARB_FORCE);
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q      <= ARB_CPU;
      cpu_rvalid_q <= 1'b0;
      spi_rvalid_q <= 1'b0;
      spi_forced_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      spi_rvalid_q <= spi_rvalid_d;
      spi_forced_q <= spi_forced_d;
    end
  end

  // RAM port mux: SPI only when granted, otherwise the CPU side parks on the bus
  always_comb begin
    ram_add = cpu_add;
    ram_din = cpu_wdata;
    ram_we  = cpu_gnt & cpu_we;
    if (spi_gnt) begin
      ram_add = spi_add;
      ram_din = spi_wdata;
      ram_we  = spi_we;
    end
  end

  assign cpu_rdata  = ram_dout;
  assign spi_rdata  = ram_dout;
  assign cpu_rvalid = cpu_rvalid_q;
  assign spi_rvalid = spi_rvalid_q;
  assign spi_forced = spi_forced_q;

endmodule

// File: tb/tb_nano_ram_arbiter.sv
// Bench for nano_ram_arbiter: directed scenarios plus random traffic against a rule-level model.
// Outputs sampled on the falling edge; inputs change 1 time unit after the rising edge.
// A behavioural sync RAM sits on the RAM port; its contents are compared at the end.
module tb_nano_ram_arbiter;
  import nano_pkg::*;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          nrst;
  logic          cpu_req, cpu_we, spi_req, spi_we, spi_lock;
  logic [AW-1:0] cpu_add, spi_add;
  logic [DW-1:0] cpu_wdata, spi_wdata;
  logic          cpu_gnt, cpu_rvalid, spi_gnt, spi_rvalid, ram_we, spi_forced;
  logic [DW-1:0] cpu_rdata, spi_rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_add;

  always #5 clk = ~clk;

  nano_ram_arbiter #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .MAX_WAIT(MW)) u_dut (
    .CLK(clk), .NRST(nrst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_add(cpu_add), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .spi_req(spi_req), .spi_we(spi_we), .spi_add(spi_add), .spi_wdata(spi_wdata),
    .spi_gnt(spi_gnt), .spi_rdata(spi_rdata), .spi_rvalid(spi_rvalid),
    .spi_lock(spi_lock),
    .ram_we(ram_we), .ram_add(ram_add), .ram_din(ram_din), .ram_dout(ram_dout),
    .spi_forced(spi_forced)
  );

  // Behavioural single-port sync RAM (registered read)
  logic [DW-1:0] ram_mem [16];
  always @(posedge clk) begin
    ram_dout <= ram_mem[ram_add];
    if (ram_we) ram_mem[ram_add] = ram_din;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: ownership flags, denial count, expected memory
  bit            m_force_slot, m_locked, m_cpu_rv, m_spi_rv, m_forced;
  int            m_wait;
  logic [DW-1:0] m_cpu_rd, m_spi_rd;
  logic [DW-1:0] exp_mem [16];
  bit            e_cpu, e_spi;
  // Observed values of the last sampled cycle, for directed checks
  logic          o_cpu, o_spi, o_we, o_frc, o_srv, o_crv;
  logic [DW-1:0] o_crd;

  task automatic cycle();
    logic          e_we;
    logic [AW-1:0] e_add;
    bit            normal, hitd, nxt_lock;
    @(negedge clk);
    // Who may own the port this cycle
    e_cpu = 1'b0;
    e_spi = 1'b0;
    if (nrst) begin
      if (m_force_slot) e_spi = spi_req;
      else if (m_locked && spi_lock) e_spi = spi_req;
      else begin
        e_cpu = cpu_req;
        e_spi = spi_req && !cpu_req;
      end
    end
    e_we  = (e_cpu && cpu_we) || (e_spi && spi_we);
    e_add = e_spi ? spi_add : cpu_add;
    chk("cpu_gnt", cpu_gnt, e_cpu);
    chk("spi_gnt", spi_gnt, e_spi);
    chk("ram_we", ram_we, e_we);
    chk("ram_add", ram_add, e_add);
    if (e_we) chk("ram_din", ram_din, e_spi ? spi_wdata : cpu_wdata);
    chk("cpu_rvalid", cpu_rvalid, m_cpu_rv);
    chk("spi_rvalid", spi_rvalid, m_spi_rv);
    chk("spi_forced", spi_forced, m_forced);
    if (m_cpu_rv) chk("cpu_rdata", cpu_rdata, m_cpu_rd);
    if (m_spi_rv) chk("spi_rdata", spi_rdata, m_spi_rd);
    o_cpu = cpu_gnt; o_spi = spi_gnt; o_we = ram_we; o_frc = spi_forced;
    o_srv = spi_rvalid; o_crv = cpu_rvalid; o_crd = cpu_rdata;
    @(posedge clk);
    if (!nrst) begin
      m_force_slot = 0; m_locked = 0; m_wait = 0;
      m_cpu_rv = 0; m_spi_rv = 0; m_forced = 0;
    end else begin
      normal   = !m_force_slot && !m_locked;
      hitd     = (m_wait == MW - 1) && spi_req && !e_spi;
      nxt_lock = (e_spi && spi_lock) || (m_locked && spi_lock);
      m_force_slot = !nxt_lock && normal && hitd;
      m_locked     = nxt_lock;
      m_forced     = m_force_slot;
      if (e_spi || !spi_req) m_wait = 0;
      else if (m_wait < MW) m_wait = m_wait + 1;
      m_cpu_rv = e_cpu && !cpu_we;
      m_spi_rv = e_spi && !spi_we;
      m_cpu_rd = exp_mem[cpu_add];
      m_spi_rd = exp_mem[spi_add];
      if (e_cpu && cpu_we) exp_mem[cpu_add] = cpu_wdata;
      if (e_spi && spi_we) exp_mem[spi_add] = spi_wdata;
    end
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; spi_req = 0; spi_we = 0; spi_lock = 0;
  endtask

  initial begin
    int first_spi, forced_at, n_spi, n_cpu;
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = DW'(16'h1000 + i * 16'h0101);
      exp_mem[i] = DW'(16'h1000 + i * 16'h0101);
    end
    ram_mem[3] = 16'hBEEF;
    exp_mem[3] = 16'hBEEF;
    m_force_slot = 0; m_locked = 0; m_wait = 0;
    m_cpu_rv = 0; m_spi_rv = 0; m_forced = 0;
    m_cpu_rd = '0; m_spi_rd = '0;
    nrst = 0; idle();
    cpu_add = '0; spi_add = '0; cpu_wdata = '0; spi_wdata = '0;
    #1;
    cycle(); cycle();
    nrst = 1;
    cycle();
    chk("reset_state", u_dut.state_q, ARB_CPU);

    // T1: CPU-only read of address 3
    cpu_req = 1; cpu_add = 4'd3;
    cycle();
    chk("t1_cpu_gnt", o_cpu, 1);
    chk("t1_spi_gnt", o_spi, 0);
    idle();
    cycle();
    chk("t1_rvalid", o_crv, 1);
    chk("t1_rdata", o_crd, 16'hBEEF);

    // T2: CPU hogging, SPI forced in after MAX_WAIT denials
    cpu_req = 1; cpu_add = 4'd1; spi_req = 1; spi_add = 4'd2;
    first_spi = -1; forced_at = -1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (o_spi && first_spi < 0) begin
        first_spi = i;
        spi_req = 0;
      end
      if (o_frc && forced_at < 0) forced_at = i;
      if (i == 4) chk("t2_cpu_off_in_slot", o_cpu, 0);
      if (i == 5) chk("t2_cpu_back", o_cpu, 1);
    end
    chk("t2_first_spi", first_spi, 4);
    chk("t2_forced_cycle", forced_at, 4);
    idle();
    cycle();

    // T3: locked SPI burst of 4 writes while the CPU keeps asking
    n_spi = 0; n_cpu = 0;
    spi_lock = 1; spi_req = 1; spi_we = 1; spi_wdata = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      spi_add = AW'(i);
      cycle();
      n_spi += int'(o_spi);
      n_cpu += int'(o_cpu);
      cpu_req = 1; cpu_add = 4'd6;
    end
    chk("t3_spi_grants", n_spi, 4);
    chk("t3_cpu_grants", n_cpu, 0);
    spi_lock = 0; spi_req = 0; spi_we = 0;
    cycle();
    chk("t3_cpu_return", o_cpu, 1);
    idle();
    cycle();

    // T4: simultaneous requests, CPU read wins, SPI write not issued
    cpu_req = 1; cpu_we = 0; cpu_add = 4'd5;
    spi_req = 1; spi_we = 1; spi_add = 4'd5; spi_wdata = 16'hDEAD;
    cycle();
    chk("t4_cpu_gnt", o_cpu, 1);
    chk("t4_no_write", o_we, 0);
    idle();
    cycle();

    // T5: reset asserted in the middle of a locked SPI write burst
    spi_lock = 1; spi_req = 1; spi_we = 1; spi_add = 4'd7; spi_wdata = 16'h5555;
    cycle();
    nrst = 0; spi_add = 4'd9; spi_wdata = 16'hAAAA;
    cycle();
    chk("t5_we_in_reset", o_we, 0);
    nrst = 1; idle();
    cycle();
    chk("t5_state", u_dut.state_q, ARB_CPU);
    chk("t5_rvalids", {o_crv, o_srv}, 2'b00);
    chk("t5_mem9", ram_mem[9], 16'h1909);

    // T6: SPI read waits into a forced slot but drops its request first
    cpu_req = 1; cpu_add = 4'd4; spi_req = 1; spi_add = 4'd2;
    for (int i = 0; i < MW; i++) cycle();
    spi_req = 0;
    cycle();
    chk("t6_no_spi_gnt", o_spi, 0);
    chk("t6_no_cpu_gnt", o_cpu, 0);
    cycle();
    chk("t6_no_spi_rvalid", o_srv, 0);
    chk("t6_cpu_back", o_cpu, 1);
    chk("t6_state", u_dut.state_q, ARB_CPU);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      nrst      = ($urandom_range(99) != 0);
      cpu_req   = ($urandom_range(99) < 60);
      cpu_we    = $urandom_range(1) == 1;
      cpu_add   = AW'($urandom);
      cpu_wdata = DW'($urandom);
      spi_req   = ($urandom_range(99) < 50);
      spi_we    = $urandom_range(1) == 1;
      spi_add   = AW'($urandom);
      spi_wdata = DW'($urandom);
      if ($urandom_range(9) == 0) spi_lock = ~spi_lock;
      cycle();
    end
    nrst = 1; idle();
    cycle();

    for (int i = 0; i < 16; i++) chk($sformatf("mem_%0d", i), ram_mem[i], exp_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
